// File: rtl/rate_transmitter.sv
// Serial line transmitter: NRZ or Manchester bits at a programmed UI length, with registered edge events.
// Optional saturating underrun counter enabled by RATE_TRANSMITTER_UNDERRUN_COUNT_EN.

package common_p;
  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;
endpackage

package clks_alot_p;
  localparam int unsigned RATE_COUNTER_WIDTH = 16;
endpackage

module rate_transmitter #(
  parameter int unsigned RATE_WIDTH           = clks_alot_p::RATE_COUNTER_WIDTH,
  parameter int unsigned UNDERRUN_COUNT_WIDTH = 8
) (
  input  common_p::clk_dom_s              sys_dom_i,
  input  logic                            tx_en_i,
  input  logic                            clear_state_i,
  input  logic                            clock_encoded_data_en_i,
  input  logic                            idle_level_i,
  input  logic [RATE_WIDTH-1:0]           rate_i,
  input  logic                            data_valid_i,
  input  logic                            data_i,
  output logic                            data_ready_o,
  output logic                            line_o,
  output logic                            rising_edge_o,
  output logic                            falling_edge_o,
  output logic                            any_edge_o,
  output logic                            bit_start_o,
  output logic                            underrun_o,
  output logic                            rate_clamped_o,
  output logic                            busy_o,
  output logic [UNDERRUN_COUNT_WIDTH-1:0] underrun_count_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_HALF_A, ST_HALF_B} state_e;

  state_e                r_state, w_state_nxt;
  logic [RATE_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [RATE_WIDTH-1:0] r_rate, w_rate_nxt;
  logic                  r_bit, w_bit_nxt;
  logic                  r_man, w_man_nxt;
  logic                  r_line, w_line_nxt;
  logic                  r_rise, r_fall, r_any;
  logic                  r_bit_start, w_bit_start_nxt;
  logic                  r_clamped, w_clamped_nxt;
  logic                  w_pulse_en;
  logic                  w_clk, w_rst_n;
  logic                  w_last, w_ready, w_xfer, w_underrun;
  logic [RATE_WIDTH-1:0] w_min_rate, w_eff_rate;

  assign w_clk   = sys_dom_i.clk;
  assign w_rst_n = sys_dom_i.rst_n;

  // Last cycle of a UI: NRZ ends in HALF_A, Manchester ends in HALF_B.
  assign w_last = ((r_state == ST_HALF_A) && !r_man && (r_cnt == '0)) ||
                  ((r_state == ST_HALF_B) && (r_cnt == '0));

  assign w_ready    = w_rst_n & tx_en_i & ~clear_state_i & ((r_state == ST_IDLE) | w_last);
  assign w_xfer     = data_valid_i & w_ready;
  assign w_underrun = w_last & tx_en_i & ~clear_state_i & ~data_valid_i;

  assign w_min_rate = clock_encoded_data_en_i ? RATE_WIDTH'(2) : RATE_WIDTH'(1);
  assign w_eff_rate = (rate_i < w_min_rate) ? w_min_rate : rate_i;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rate_nxt      = r_rate;
    w_bit_nxt       = r_bit;
    w_man_nxt       = r_man;
    w_line_nxt      = r_line;
    w_bit_start_nxt = 1'b0;
    w_clamped_nxt   = 1'b0;
    w_pulse_en      = 1'b1;
    if (clear_state_i) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_line_nxt  = idle_level_i;
      w_pulse_en  = 1'b0;
    end else if (w_xfer) begin
      w_state_nxt     = ST_HALF_A;
      w_bit_nxt       = data_i;
      w_man_nxt       = clock_encoded_data_en_i;
      w_rate_nxt      = w_eff_rate;
      w_cnt_nxt       = clock_encoded_data_en_i ? ((w_eff_rate >> 1) - RATE_WIDTH'(1))
                                                : (w_eff_rate - RATE_WIDTH'(1));
      w_line_nxt      = clock_encoded_data_en_i ? ~data_i : data_i;
      w_bit_start_nxt = 1'b1;
      w_clamped_nxt   = (rate_i < w_min_rate);
    end else begin
      case (r_state)
        ST_IDLE: w_line_nxt = idle_level_i;
        ST_HALF_A: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - RATE_WIDTH'(1);
          end else if (r_man) begin
            // Odd R leaves the extra cycle in the second half.
            w_state_nxt = ST_HALF_B;
            w_cnt_nxt   = r_rate - (r_rate >> 1) - RATE_WIDTH'(1);
            w_line_nxt  = r_bit;
          end else begin
            w_state_nxt = ST_IDLE;
            w_line_nxt  = idle_level_i;
          end
        end
        ST_HALF_B: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - RATE_WIDTH'(1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_line_nxt  = idle_level_i;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_line_nxt  = idle_level_i;
        end
      endcase
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rate      <= '0;
      r_bit       <= 1'b0;
      r_man       <= 1'b0;
      r_line      <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_any       <= 1'b0;
      r_bit_start <= 1'b0;
      r_clamped   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rate      <= w_rate_nxt;
      r_bit       <= w_bit_nxt;
      r_man       <= w_man_nxt;
      r_line      <= w_line_nxt;
      r_rise      <= w_pulse_en & w_line_nxt & ~r_line;
      r_fall      <= w_pulse_en & ~w_line_nxt & r_line;
      r_any       <= w_pulse_en & (w_line_nxt ^ r_line);
      r_bit_start <= w_bit_start_nxt;
      r_clamped   <= w_clamped_nxt;
    end
  end

`ifdef RATE_TRANSMITTER_UNDERRUN_COUNT_EN
  logic [UNDERRUN_COUNT_WIDTH-1:0] r_ucnt;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ucnt <= '0;
    end else if (clear_state_i) begin
      r_ucnt <= '0;
    end else if (w_underrun && (r_ucnt != '1)) begin
      r_ucnt <= r_ucnt + UNDERRUN_COUNT_WIDTH'(1);
    end
  end

  assign underrun_count_o = r_ucnt;
`else
  assign underrun_count_o = '0;
`endif

  assign data_ready_o   = w_ready;
  assign line_o         = r_line;
  assign rising_edge_o  = r_rise;
  assign falling_edge_o = r_fall;
  assign any_edge_o     = r_any;
  assign bit_start_o    = r_bit_start;
  assign underrun_o     = w_underrun;
  assign rate_clamped_o = r_clamped;
  assign busy_o         = (r_state != ST_IDLE);

endmodule
